tile_scheduler: RTL and testbench

- Sequences one full output feature map through the tile writer and its upstream tile compute engine.
- Walks the image in row-major tile order and clips the tile size at the right and bottom edges.
- Issues one start pulse per tile, with a stable per-tile configuration, and waits for the writer's done before moving to the next tile.
- Sits between the layer controller (frame-level start/done) and the tile compute + tile writer pair.

---
 rtl/tile_pkg.sv | 23 ++
 rtl/tile_coord_gen.sv | 84 ++++++++
 rtl/tile_scheduler.sv | 145 ++++++++++++++
 tb/tb_tile_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile scheduler: FSM states, the dimension type
// and the edge-clipping function.
package tile_pkg;

  localparam int TILE_DIM_W = 16;

  typedef logic [TILE_DIM_W-1:0] dim_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT
  } sched_state_t;

  // Tile extent starting at origin, cut back so the tile never runs past limit.
  function automatic dim_t clip_dim(input dim_t nominal, input dim_t limit, input dim_t origin);
    dim_t remain;
    remain = limit - origin;
    return (nominal < remain) ? nominal : remain;
  endfunction

endpackage

// File: rtl/tile_coord_gen.sv
// Row-major tile walker: origin/size/index registers plus the last-tile detect.
// DIM_W must equal tile_pkg::TILE_DIM_W because clipping uses dim_t.
module tile_coord_gen
  import tile_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             advance,
  input  logic [DIM_W-1:0] img_h,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] tile_h_nom,
  input  logic [DIM_W-1:0] tile_w_nom,
  output logic [DIM_W-1:0] tile_row,
  output logic [DIM_W-1:0] tile_col,
  output logic [DIM_W-1:0] tile_h,
  output logic [DIM_W-1:0] tile_w,
  output logic [CNT_W-1:0] tile_idx,
  output logic             last_tile
);

  logic [DIM_W-1:0] row_d, row_q, col_d, col_q, h_d, h_q, w_d, w_q;
  logic [CNT_W-1:0] idx_d, idx_q;
  logic [DIM_W:0]   col_step, row_end, col_end;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    row_d    = row_q;
    col_d    = col_q;
    h_d      = h_q;
    w_d      = w_q;
    idx_d    = idx_q;
    col_step = {1'b0, col_q} + {1'b0, tile_w_nom};
    if (init) begin
      row_d = '0;
      col_d = '0;
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + 1'b1;
      if (col_step >= {1'b0, img_w}) begin
        col_d = '0;
        row_d = row_q + tile_h_nom;
      end else begin
        col_d = col_step[DIM_W-1:0];
      end
    end
    if (init || advance) begin
      h_d = clip_dim(tile_h_nom, img_h, row_d);
      w_d = clip_dim(tile_w_nom, img_w, col_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      h_q   <= '0;
      w_q   <= '0;
      idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      row_q <= row_d;
      col_q <= col_d;
      h_q   <= h_d;
      w_q   <= w_d;
      idx_q <= idx_d;
    end
  end

  // One extra bit so origin + size cannot wrap before the compare.
  assign row_end   = {1'b0, row_q} + {1'b0, h_q};
  assign col_end   = {1'b0, col_q} + {1'b0, w_q};
  assign last_tile = (row_end == {1'b0, img_h}) && (col_end == {1'b0, img_w});

  assign tile_row = row_q;
  assign tile_col = col_q;
  assign tile_h   = h_q;
  assign tile_w   = w_q;
  assign tile_idx = idx_q;

endmodule

// File: rtl/tile_scheduler.sv
// Frame-level sequencer: issues one tile_start per tile, waits for the writer's
// wr_done, and pulses frame_done after the last tile. abort returns to idle silently.
module tile_scheduler
  import tile_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_tile_h,
  input  logic [DIM_W-1:0]  cfg_tile_w,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              tile_start,
  output logic [DIM_W-1:0]  tile_row,
  output logic [DIM_W-1:0]  tile_col,
  output logic [DIM_W-1:0]  tile_h,
  output logic [DIM_W-1:0]  tile_w,
  output logic [DIM_W-1:0]  out_img_h,
  output logic [DIM_W-1:0]  out_img_w,
  output logic [ADDR_W-1:0] out_base_addr,
  input  logic              wr_done,
  output logic              busy,
  output logic [CNT_W-1:0]  tile_idx,
  output logic              frame_done
);

  sched_state_t      state_d, state_q;
  logic [DIM_W-1:0]  img_h_d, img_h_q, img_w_d, img_w_q;
  logic [DIM_W-1:0]  tile_h_nom_d, tile_h_nom_q, tile_w_nom_d, tile_w_nom_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic              frame_done_d, frame_done_q;
  logic              init, advance, last_tile, cfg_zero;

  assign cfg_zero = (cfg_img_h == '0) || (cfg_img_w == '0) ||
                    (cfg_tile_h == '0) || (cfg_tile_w == '0);

  always_comb begin
    state_d      = state_q;
    img_h_d      = img_h_q;
    img_w_d      = img_w_q;
    tile_h_nom_d = tile_h_nom_q;
    tile_w_nom_d = tile_w_nom_q;
    base_d       = base_q;
    frame_done_d = 1'b0;
    init         = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          img_h_d      = cfg_img_h;
          img_w_d      = cfg_img_w;
          tile_h_nom_d = cfg_tile_h;
          tile_w_nom_d = cfg_tile_w;
          base_d       = cfg_base_addr;
          if (cfg_zero) begin
            frame_done_d = 1'b1;
          end else begin
            init    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wr_done) begin
          if (last_tile) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        advance = 1'b1;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a same-cycle start in IDLE.
    if (abort) begin
      state_d      = IDLE;
      img_h_d      = img_h_q;
      img_w_d      = img_w_q;
      tile_h_nom_d = tile_h_nom_q;
      tile_w_nom_d = tile_w_nom_q;
      base_d       = base_q;
      frame_done_d = 1'b0;
      init         = 1'b0;
      advance      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      img_h_q      <= '0;
      img_w_q      <= '0;
      tile_h_nom_q <= '0;
      tile_w_nom_q <= '0;
      base_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      img_h_q      <= img_h_d;
      img_w_q      <= img_w_d;
      tile_h_nom_q <= tile_h_nom_d;
      tile_w_nom_q <= tile_w_nom_d;
      base_q       <= base_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Tile 0 is clipped against the incoming cfg since the latched copy updates on the same edge.
  tile_coord_gen #(.DIM_W(DIM_W), .CNT_W(CNT_W)) u_coord (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .advance    (advance),
    .img_h      (init ? cfg_img_h  : img_h_q),
    .img_w      (init ? cfg_img_w  : img_w_q),
    .tile_h_nom (init ? cfg_tile_h : tile_h_nom_q),
    .tile_w_nom (init ? cfg_tile_w : tile_w_nom_q),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .tile_h     (tile_h),
    .tile_w     (tile_w),
    .tile_idx   (tile_idx),
    .last_tile  (last_tile)
  );

  assign tile_start    = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign frame_done    = frame_done_q;
  assign out_img_h     = img_h_q;
  assign out_img_w     = img_w_q;
  assign out_base_addr = base_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a reference tile walk is queued per frame
// and popped against every tile_start the DUT produces.
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        wr_done = 1'b0;
  logic [15:0] cfg_img_h = '0, cfg_img_w = '0, cfg_tile_h = '0, cfg_tile_w = '0;
  logic [31:0] cfg_base_addr = '0;
  logic        tile_start, busy, frame_done;
  logic [15:0] tile_row, tile_col, tile_h, tile_w, out_img_h, out_img_w, tile_idx;
  logic [31:0] out_base_addr;

  typedef struct {
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] h;
    logic [15:0] w;
    logic [15:0] idx;
  } tile_t;

  tile_t sb[$];
  int    tests = 0;
  int    fails = 0;
  int    n_tile_start = 0;
  int    n_frame_done = 0;

  tile_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_img_h     (cfg_img_h),
    .cfg_img_w     (cfg_img_w),
    .cfg_tile_h    (cfg_tile_h),
    .cfg_tile_w    (cfg_tile_w),
    .cfg_base_addr (cfg_base_addr),
    .tile_start    (tile_start),
    .tile_row      (tile_row),
    .tile_col      (tile_col),
    .tile_h        (tile_h),
    .tile_w        (tile_w),
    .out_img_h     (out_img_h),
    .out_img_w     (out_img_w),
    .out_base_addr (out_base_addr),
    .wr_done       (wr_done),
    .busy          (busy),
    .tile_idx      (tile_idx),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tile_start === 1'b1) n_tile_start++;
    if (frame_done === 1'b1) n_frame_done++;
  end

  // All bench activity sits 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_tile(input string tag, input tile_t e);
    tests++;
    if ({tile_row, tile_col, tile_h, tile_w, tile_idx} !== {e.row, e.col, e.h, e.w, e.idx}) begin
      fails++;
      $display("FAIL %s: got row=%0d col=%0d h=%0d w=%0d idx=%0d, expected row=%0d col=%0d h=%0d w=%0d idx=%0d",
               tag, tile_row, tile_col, tile_h, tile_w, tile_idx, e.row, e.col, e.h, e.w, e.idx);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame; abort_at / restart_at name the tile whose WAIT gets an abort / a stray start.
  task automatic run_frame(input logic [15:0] ih, input logic [15:0] iw, input logic [15:0] th,
                           input logic [15:0] tw, input logic [31:0] base,
                           input int abort_at, input int restart_at);
    tile_t e;
    int    n = 0;
    int    waited;
    int    ts0, fd0;
    sb.delete();
    for (int r = 0; r < int'(ih); r += int'(th)) begin
      for (int c = 0; c < int'(iw); c += int'(tw)) begin
        e.row = 16'(r);
        e.col = 16'(c);
        e.h   = (int'(th) < int'(ih) - r) ? th : 16'(int'(ih) - r);
        e.w   = (int'(tw) < int'(iw) - c) ? tw : 16'(int'(iw) - c);
        e.idx = 16'(n);
        sb.push_back(e);
        n++;
      end
    end
    ts0 = n_tile_start;
    fd0 = n_frame_done;
    cfg_img_h = ih; cfg_img_w = iw; cfg_tile_h = th; cfg_tile_w = tw; cfg_base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
    while (sb.size() > 0) begin
      waited = 0;
      while (tile_start !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      if (waited >= 20) begin
        tests++;
        fails++;
        $display("FAIL tile_start timeout: got no pulse in 20 cycles, expected tile %0d", sb[0].idx);
        sb.delete();
        return;
      end
      e = sb.pop_front();
      check_int($sformatf("tile%0d start latency", e.idx), waited, (e.idx == 0) ? 0 : 1);
      check_tile($sformatf("tile%0d fields", e.idx), e);
      tests++;
      if ({out_img_h, out_img_w, out_base_addr} !== {ih, iw, base}) begin
        fails++;
        $display("FAIL tile%0d out_cfg: got %0d/%0d/%h, expected %0d/%0d/%h",
                 e.idx, out_img_h, out_img_w, out_base_addr, ih, iw, base);
      end
      step();
      check_bit($sformatf("tile%0d start single-cycle", e.idx), tile_start, 1'b0);
      if (int'(e.idx) == restart_at) begin
        cfg_img_h = ih + 16'd6; cfg_img_w = iw + 16'd6; cfg_tile_h = 16'd3; cfg_tile_w = 16'd3;
        cfg_base_addr = 32'hdead_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_img_h = ih; cfg_img_w = iw; cfg_tile_h = th; cfg_tile_w = tw; cfg_base_addr = base;
        check_tile($sformatf("tile%0d after stray start", e.idx), e);
        tests++;
        if (out_base_addr !== base) begin
          fails++;
          $display("FAIL stray start base: got %h, expected %h", out_base_addr, base);
        end
      end else begin
        step();
      end
      if (int'(e.idx) == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_bit("abort busy", busy, 1'b0);
        check_tile("abort tile hold", e);
        repeat (10) step();
        check_int("abort tile_start count", n_tile_start - ts0, int'(e.idx) + 1);
        check_int("abort frame_done count", n_frame_done - fd0, 0);
        check_bit("abort busy stays low", busy, 1'b0);
        sb.delete();
        return;
      end
      step();
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
      if (sb.size() == 0) begin
        check_bit("frame_done at wr_done+1", frame_done, 1'b1);
        check_bit("busy drops with frame_done", busy, 1'b0);
      end else begin
        check_bit($sformatf("tile%0d no early frame_done", e.idx), frame_done, 1'b0);
        check_bit($sformatf("tile%0d busy held", e.idx), busy, 1'b1);
      end
    end
    step();
    check_bit("frame_done single-cycle", frame_done, 1'b0);
    check_int("tile_start count", n_tile_start - ts0, n);
    check_int("frame_done count", n_frame_done - fd0, 1);
  endtask

  task automatic test_reset();
    repeat (2) step();
    tests++;
    if ({tile_start, busy, frame_done, tile_idx, tile_row, tile_col, tile_h, tile_w,
         out_img_h, out_img_w, out_base_addr} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got nonzero (busy=%b idx=%0d row=%0d base=%h), expected all 0",
               busy, tile_idx, tile_row, out_base_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    run_frame(16'd10, 16'd10, 16'd4, 16'd4, 32'h0000_1000, -1, -1);
  endtask

  task automatic test_spurious_idle();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    check_bit("idle wr_done busy", busy, 1'b0);
    check_int("idle wr_done tile_idx", int'(tile_idx), 8);
    check_bit("idle wr_done tile_start", tile_start, 1'b0);
  endtask

  task automatic test_single_tile();
    run_frame(16'd8, 16'd8, 16'd8, 16'd8, 32'h0000_2000, -1, -1);
  endtask

  task automatic test_spurious_issue();
    int fd0;
    fd0 = n_frame_done;
    cfg_img_h = 16'd8; cfg_img_w = 16'd8; cfg_tile_h = 16'd8; cfg_tile_w = 16'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bit("issue tile_start", tile_start, 1'b1);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    repeat (3) step();
    check_bit("issue wr_done ignored busy", busy, 1'b1);
    check_int("issue wr_done no frame_done", n_frame_done - fd0, 0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_bit("issue frame_done after real wr_done", frame_done, 1'b1);
    step();
  endtask

  task automatic test_zero_cfg();
    int ts0;
    ts0 = n_tile_start;
    cfg_img_h = 16'd10; cfg_img_w = 16'd0; cfg_tile_h = 16'd4; cfg_tile_w = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bit("zero cfg frame_done", frame_done, 1'b1);
    check_bit("zero cfg busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_bit($sformatf("zero cfg busy c%0d", i), busy, 1'b0);
    end
    check_int("zero cfg tile_start count", n_tile_start - ts0, 0);
  endtask

  task automatic test_start_during_wait();
    run_frame(16'd10, 16'd10, 16'd4, 16'd4, 32'h0000_3000, -1, 1);
  endtask

  task automatic test_abort();
    run_frame(16'd10, 16'd10, 16'd4, 16'd4, 32'h0000_4000, 3, -1);
    run_frame(16'd10, 16'd10, 16'd4, 16'd4, 32'h0000_4000, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    cfg_img_h = 16'd10; cfg_img_w = 16'd10; cfg_tile_h = 16'd4; cfg_tile_w = 16'd4;
    cfg_base_addr = 32'h0000_5000;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_bit("mid-frame busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tile_start, busy, frame_done, tile_idx, tile_row, tile_col, tile_h, tile_w,
         out_img_h, out_img_w, out_base_addr} !== '0) begin
      fails++;
      $display("FAIL async reset outputs: got busy=%b h=%0d w=%0d base=%h, expected all 0",
               busy, tile_h, tile_w, out_base_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    check_bit("post reset busy", busy, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_spurious_idle();
    test_single_tile();
    test_spurious_issue();
    test_zero_cfg();
    test_start_during_wait();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
